// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tt_sweep_pkg
//  Description : Shared types and helpers for the truth-table sweeper.
//                - tt_state_e  : sweep FSM state encoding
//                - TT_VECTORS  : number of input combinations of a 3-input gate
//                - tt_code_bit : maps input index to its bit in the function code
//  Revision    : 1.0 - initial release
// ============================================================================
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  localparam int TT_VECTORS = 8;

  // Wolfram-style code: the response to index 0 lands in the MSB.
  function automatic logic [2:0] tt_code_bit(input logic [2:0] idx);
    return 3'd7 - idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_vector_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tt_vector_sampler
//  Description : Per-vector timing and sampling for the truth-table sweeper.
//                Counts the settle interval, then samples dut_out for
//                SAMPLE_CYCLES cycles, keeping the first sample and flagging
//                any later sample that disagrees with it.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                settle_en         - top FSM is in SETTLE
//                sample_en         - top FSM is in SAMPLE
//                dut_out           - response of the gate under test
//                settle_done       - last settle cycle (combinational)
//                vec_done          - last sample cycle (combinational)
//                vec_bit           - first sample of the current vector
//                vec_glitch        - this cycle's sample differs from the first
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_vector_sampler #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic settle_en,
  input  logic sample_en,
  input  logic dut_out,
  output logic settle_done,
  output logic vec_done,
  output logic vec_bit,
  output logic vec_glitch
);

  localparam int c_SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int c_MW = $clog2(SAMPLE_CYCLES) + 1;

  localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);
  localparam logic [c_MW-1:0] c_SAMPLE_LAST = c_MW'(SAMPLE_CYCLES - 1);
  localparam logic [c_SW-1:0] c_SETTLE_ONE  = c_SW'(1);
  localparam logic [c_MW-1:0] c_SAMPLE_ONE  = c_MW'(1);

  logic [c_SW-1:0] r_settle_cnt;
  logic [c_MW-1:0] r_sample_cnt;
  logic            r_first;
  logic            w_first_sample;

  assign w_first_sample = (r_sample_cnt == '0);

  assign settle_done = settle_en && (r_settle_cnt == c_SETTLE_LAST);
  assign vec_done    = sample_en && (r_sample_cnt == c_SAMPLE_LAST);

  // During the first sample cycle the live response is the first sample;
  // afterwards the captured copy is reported so the code bit stays stable.
  assign vec_bit    = w_first_sample ? dut_out : r_first;
  assign vec_glitch = sample_en && !w_first_sample && (dut_out != r_first);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle_cnt <= '0;
      r_sample_cnt <= '0;
      r_first      <= 1'b0;
    end else begin
      // Counters rewind on their last cycle so the next vector starts clean.
      if (settle_en && !settle_done) begin
        r_settle_cnt <= r_settle_cnt + c_SETTLE_ONE;
      end else begin
        r_settle_cnt <= '0;
      end

      if (sample_en && !vec_done) begin
        r_sample_cnt <= r_sample_cnt + c_SAMPLE_ONE;
      end else begin
        r_sample_cnt <= '0;
      end

      if (sample_en && w_first_sample) begin
        r_first <= dut_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper
//  Description : Reads back the logic function of a 3-input, 1-output gate.
//                Steps {in1,in2,in3} through 0..7, holds each vector for
//                SETTLE_CYCLES, samples the response SAMPLE_CYCLES times and
//                assembles the 8-bit Wolfram-style function code plus
//                per-bit instability flags.
//  Ports       : clk, reset              - clock, synchronous active-high reset
//                start                   - begin a sweep (honoured in IDLE)
//                expected[7:0]           - reference code, latched on start
//                busy                    - sweep in progress
//                done                    - one-cycle pulse, results valid
//                code[7:0]               - extracted function code
//                unstable[7:0]           - per-code-bit glitch flags
//                match                   - code == expected and no glitches
//                dut_in1/dut_in2/dut_in3 - stimulus to the gate
//                dut_out                 - gate response
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,   // must be >= 1
  parameter int SAMPLE_CYCLES = 2    // must be >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic [7:0] unstable,
  output logic       match,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       dut_in3,
  input  logic       dut_out
);

  localparam logic [2:0] c_LAST_IDX = 3'(TT_VECTORS - 1);

  tt_state_e  r_state;
  logic [2:0] r_idx;
  logic [7:0] r_expected_q;

  logic       w_settle_done;
  logic       w_vec_done;
  logic       w_vec_bit;
  logic       w_vec_glitch;
  logic [2:0] w_bit;
  logic [7:0] w_code_next;
  logic [7:0] w_unstable_next;

  tt_vector_sampler #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SAMPLE_CYCLES (SAMPLE_CYCLES)
  ) u_sampler (
    .clk         (clk),
    .reset       (reset),
    .settle_en   (r_state == SETTLE),
    .sample_en   (r_state == SAMPLE),
    .dut_out     (dut_out),
    .settle_done (w_settle_done),
    .vec_done    (w_vec_done),
    .vec_bit     (w_vec_bit),
    .vec_glitch  (w_vec_glitch)
  );

  assign w_bit = tt_code_bit(r_idx);

  // Next-value view of the result registers; match is evaluated on these so
  // the final vector's bit is included on the edge that enters DONE.
  always_comb begin
    w_code_next     = code;
    w_unstable_next = unstable;
    if (r_state == SAMPLE) begin
      w_code_next[w_bit]     = w_vec_bit;
      w_unstable_next[w_bit] = unstable[w_bit] | w_vec_glitch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state                     <= IDLE;
      r_idx                       <= 3'd0;
      r_expected_q                <= 8'h00;
      busy                        <= 1'b0;
      done                        <= 1'b0;
      code                        <= 8'h00;
      unstable                    <= 8'h00;
      match                       <= 1'b0;
      {dut_in1, dut_in2, dut_in3} <= 3'd0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state                     <= SETTLE;
            r_idx                       <= 3'd0;
            r_expected_q                <= expected;
            busy                        <= 1'b1;
            code                        <= 8'h00;
            unstable                    <= 8'h00;
            match                       <= 1'b0;
            {dut_in1, dut_in2, dut_in3} <= 3'd0;
          end
        end

        SETTLE: begin
          if (w_settle_done) begin
            r_state <= SAMPLE;
          end
        end

        SAMPLE: begin
          code     <= w_code_next;
          unstable <= w_unstable_next;
          if (w_vec_done) begin
            if (r_idx == c_LAST_IDX) begin
              r_state                     <= DONE;
              done                        <= 1'b1;
              match                       <= (w_code_next == r_expected_q) &&
                                             (w_unstable_next == 8'h00);
              {dut_in1, dut_in2, dut_in3} <= 3'd0;
            end else begin
              // Stimulus changes on the same edge that re-enters SETTLE.
              r_state                     <= SETTLE;
              r_idx                       <= r_idx + 3'd1;
              {dut_in1, dut_in2, dut_in3} <= r_idx + 3'd1;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Sequential characterizer that reads back the logic function of a 3-input, 1-output gate (for example a compiled 0xB9 circuit).
- Drives every input combination `{in1,in2,in3}` = 0..7 in turn, waits a settle interval, then samples the response several times.
- Assembles the results into the 8-bit Wolfram-style function code and flags any vector whose samples disagree.
- Sits between the test/characterization controller and the combinational gate under test.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles each vector is held before sampling begins; must be ≥1.
- `SAMPLE_CYCLES`, default 2: consecutive cycles `dut_out` is sampled per vector; must be ≥1.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a sweep; honoured only in IDLE.
- `expected` input 8: reference code, sampled on the accepted `start`.
- `busy` output 1: sweep in progress.
- `done` output 1: one-cycle pulse when results are valid.
- `code` output 8: extracted function code.
- `unstable` output 8: per-code-bit glitch flags.
- `match` output 1: `code == expected_q && unstable == 0`.
- `dut_in1`, `dut_in2`, `dut_in3` output 1 each: stimulus to the gate.
- `dut_out` input 1: gate response.

## Operation
- Bit mapping: the response to input index i = `{in1,in2,in3}` is stored in `code[7-i]`. A gate with truth-table outputs 1,0,1,1,1,0,0,1 for i = 0..7 yields `code` = 0xB9.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE → SETTLE on `start`. The same edge sets idx=0, clears `code`, `unstable` and `match`, and latches `expected`.
- SETTLE: drive `{dut_in1,dut_in2,dut_in3}` = idx for exactly `SETTLE_CYCLES` cycles, then go to SAMPLE.
- SAMPLE: sample `dut_out` once per cycle for `SAMPLE_CYCLES` cycles.
  - The first sample is written to `code[7-idx]`.
  - Any later sample that differs from the first sets `unstable[7-idx]`; `code` keeps the first sample.
- After the last sample:
  - idx<7: idx+1 → SETTLE.
  - idx==7: → DONE.
- DONE: `done`=1 and `match` updated for one cycle, then → IDLE.
- In IDLE, `dut_in*` = 000. `code`, `unstable` and `match` hold their values until the next accepted `start`.
- `start` while `busy` is ignored and has no effect on the sweep.
- Reset values: state IDLE, `busy`=0, `done`=0, `code`=0x00, `unstable`=0x00, `match`=0, `dut_in*`=000, `expected_q`=0x00.
- Reset during a sweep: the sweep is aborted and all outputs take their reset values on that edge; no `done` is produced.
- Counters are sized with `$clog2` of their parameter plus 1. idx is 3 bits and never wraps, because the FSM exits at 7.

## Timing
- Each vector takes `SETTLE_CYCLES`+`SAMPLE_CYCLES` cycles. The stimulus changes on the edge that enters SETTLE.
- Start accepted at edge k:
  - `busy`=1 from edge k through the edge that leaves DONE.
  - `done` is high in the cycle beginning at edge k + 8·(S+M).
  - With default parameters, `done` asserts 48 cycles after acceptance and the sweep occupies 49 busy cycles.
- `dut_out` is sampled combinationally at the edge ending each SAMPLE cycle. The gate must settle within `SETTLE_CYCLES`.
- `start` arriving in the DONE cycle is ignored. `start` in the first IDLE cycle after DONE is accepted.

## Structure
- Package `tt_sweep_pkg` contains:
  - state enum `tt_state_e` {IDLE, SETTLE, SAMPLE, DONE};
  - constant `TT_VECTORS`=8;
  - function `tt_code_bit(idx)` returning 7-idx.
- Sub-module `tt_vector_sampler` is natural. It owns the settle/sample counters and the first-sample/mismatch logic for one vector, and signals `vec_done`, `vec_bit` and `vec_glitch` to the top FSM.

## Test plan
- Behavioural 0xB9 gate with zero delay, `expected`=0xB9 → `done` after 48 cycles, `code`=0xB9, `unstable`=0x00, `match`=1.
- Same gate, `expected`=0x8E → `code`=0xB9, `match`=0.
- Gate with 3-cycle output delay → `code`=0xB9 when `SETTLE_CYCLES`=4. With `SETTLE_CYCLES`=1, `code` must equal the model-predicted skewed value (not 0xB9) and `match`=0.
- Model that toggles `dut_out` during the second sample cycle of index 3, `SAMPLE_CYCLES`=2 → `unstable`=0x10, `match`=0, `code[4]` equals the first sample.
- `reset` asserted at cycle 20 of a sweep → all outputs zero on the next edge, no `done`. A new `start` then yields a full correct sweep.
- `start` pulsed at cycles 5 and 30 of a running sweep → ignored: exactly one `done`, at the original cycle 48.
